// File: rtl/stopwatch_sequencer_pkg.sv
// Shared definitions for the stopwatch sequencer: state encoding, BCD limits
// and the adj/sel to mode mapping used by both the run and paused paths.
package stopwatch_sequencer_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
   localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

   typedef logic [1:0] state_t;

   localparam state_t StRun    = 2'd0;
   localparam state_t StPaused = 2'd1;
   localparam state_t StAdjMin = 2'd2;
   localparam state_t StAdjSec = 2'd3;

   // Mode requested by the adjust controls when not paused.
   function automatic state_t mode_select(input logic adj, input logic sel);
      if (!adj) begin
         return StRun;
      end
      return sel ? StAdjSec : StAdjMin;
   endfunction

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// Bundle of tick/control inputs and display outputs of the stopwatch sequencer.
//   master: drives ticks and controls, observes digits/blanking/paused
//   slave : the sequencer itself
interface stopwatch_sequencer_if;
   import stopwatch_sequencer_pkg::*;

   logic               tick_1hz;
   logic               tick_2hz;
   logic               tick_blink;
   logic               pause_pulse;
   logic               adj;
   logic               sel;
   logic [DIGIT_W-1:0] min_tens;
   logic [DIGIT_W-1:0] min_ones;
   logic [DIGIT_W-1:0] sec_tens;
   logic [DIGIT_W-1:0] sec_ones;
   logic               blank_min;
   logic               blank_sec;
   logic               paused;

   modport master (
      output tick_1hz, tick_2hz, tick_blink, pause_pulse, adj, sel,
      input  min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, paused
   );

   modport slave (
      input  tick_1hz, tick_2hz, tick_blink, pause_pulse, adj, sel,
      output min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, paused
   );

endinterface

// File: rtl/stopwatch_sequencer_bcd_mod60.sv
// Two-digit BCD counter 00..59.
//   clk, rst : clock, asynchronous active-low reset (clears to 00)
//   inc      : advance by one this cycle
//   tens/ones: registered BCD digits
//   carry    : high in the cycle an increment wraps 59 -> 00
module bcd_mod60
   import stopwatch_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               carry
);

   logic [DIGIT_W-1:0] tens_q, tens_d;
   logic [DIGIT_W-1:0] ones_q, ones_d;
   logic               at_max;

   assign at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
   assign carry  = inc & at_max;

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (inc) begin
         if (ones_q == ONES_MAX) begin
            ones_d = '0;
            tens_d = (tens_q == TENS_MAX) ? '0 : tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch time sequencer: owns mm:ss, steps it from 1 Hz (run) or 2 Hz
// (adjust) ticks and tracks RUN / PAUSED / ADJ_MIN / ADJ_SEC from the
// pause, adj and sel controls.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : stopwatch_sequencer_if.slave (ticks/controls in, digits,
//              blank_min/blank_sec and paused out; all outputs registered)
// Optional feature: STOPWATCH_BLINK_EN builds the blink phase register that
// blanks the field under adjustment; otherwise blanking is tied low.
module stopwatch_sequencer
   import stopwatch_sequencer_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   stopwatch_sequencer_if.slave   bus
);

   state_t state_q, state_d;
   logic   sec_inc;
   logic   min_inc;
   logic   sec_carry;
   logic   min_carry_unused;

   // Pause has priority; PAUSED ignores adj/sel until the next press.
   always_comb begin
      state_d = state_q;
      if (bus.pause_pulse) begin
         state_d = (state_q == StPaused) ? mode_select(bus.adj, bus.sel) : StPaused;
      end else if (state_q != StPaused) begin
         state_d = mode_select(bus.adj, bus.sel);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Increment decisions use the state held before the edge.
   assign sec_inc = ((state_q == StRun) & bus.tick_1hz) |
                    ((state_q == StAdjSec) & bus.tick_2hz);
   assign min_inc = ((state_q == StRun) & sec_carry) |
                    ((state_q == StAdjMin) & bus.tick_2hz);

   bcd_mod60 u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (sec_inc),
      .tens  (bus.sec_tens),
      .ones  (bus.sec_ones),
      .carry (sec_carry)
   );

   // Minutes wrapping 59 -> 00 needs no further action.
   bcd_mod60 u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (min_inc),
      .tens  (bus.min_tens),
      .ones  (bus.min_ones),
      .carry (min_carry_unused)
   );

   assign bus.paused = (state_q == StPaused);

`ifdef STOPWATCH_BLINK_EN
   logic phase_q, phase_d;

   // A state change restarts the blink with the field visible.
   always_comb begin
      phase_d = phase_q;
      if (state_d != state_q) begin
         phase_d = 1'b0;
      end else if (bus.tick_blink) begin
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign bus.blank_min = (state_q == StAdjMin) & phase_q;
   assign bus.blank_sec = (state_q == StAdjSec) & phase_q;
`else
   logic tick_blink_unused;
   assign tick_blink_unused = bus.tick_blink;
   assign bus.blank_min     = 1'b0;
   assign bus.blank_sec     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Scoreboard bench for stopwatch_sequencer: directed scenarios followed by
// random traffic, expected outputs from a seconds-count reference model.
module tb_stopwatch_sequencer;

   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [3:0] st;
      logic [3:0] so;
      logic       bm;
      logic       bs;
      logic       p;
   } obs_t;

   localparam int MRun = 0, MPaused = 1, MAdjMin = 2, MAdjSec = 3;

   logic clk;
   logic rst;
   stopwatch_sequencer_if sw_if ();

   stopwatch_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (sw_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   // Reference model: total elapsed seconds, current mode, blink phase.
   int m_sec   = 0;
   int m_mode  = MRun;
   bit m_phase = 1'b0;

   function automatic int pick(input bit a, input bit s);
      if (!a) return MRun;
      return s ? MAdjSec : MAdjMin;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      int   mm, ss;
      mm   = m_sec / 60;
      ss   = m_sec % 60;
      o.mt = 4'(mm / 10);
      o.mo = 4'(mm % 10);
      o.st = 4'(ss / 10);
      o.so = 4'(ss % 10);
      o.bm = (m_mode == MAdjMin) && m_phase;
      o.bs = (m_mode == MAdjSec) && m_phase;
      o.p  = (m_mode == MPaused);
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.mt = sw_if.min_tens;
      o.mo = sw_if.min_ones;
      o.st = sw_if.sec_tens;
      o.so = sw_if.sec_ones;
      o.bm = sw_if.blank_min;
      o.bs = sw_if.blank_sec;
      o.p  = sw_if.paused;
      return o;
   endfunction

   task automatic model_step(input bit t1, t2, tb, pp, a, s);
      int mm, ss, nm;
      mm = m_sec / 60;
      ss = m_sec % 60;
      if (m_mode == MRun && t1) m_sec = (m_sec + 1) % 3600;
      if (m_mode == MAdjMin && t2) m_sec = ((mm + 1) % 60) * 60 + ss;
      if (m_mode == MAdjSec && t2) m_sec = mm * 60 + (ss + 1) % 60;
      if (pp) nm = (m_mode == MPaused) ? pick(a, s) : MPaused;
      else    nm = (m_mode == MPaused) ? MPaused : pick(a, s);
`ifdef STOPWATCH_BLINK_EN
      if (nm != m_mode) m_phase = 1'b0;
      else if (tb)      m_phase = ~m_phase;
`else
      m_phase = 1'b0;
`endif
      m_mode = nm;
   endtask

   task automatic check(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h%0h:%0h%0h bm=%0b bs=%0b p=%0b, required %0h%0h:%0h%0h bm=%0b bs=%0b p=%0b",
                  name, got.mt, got.mo, got.st, got.so, got.bm, got.bs, got.p,
                  exp.mt, exp.mo, exp.st, exp.so, exp.bm, exp.bs, exp.p);
      end
   endtask

   // One clock of stimulus: drive at negedge, push the post-edge expectation.
   task automatic cyc(input bit t1, t2, tb, pp, a, s);
      @(negedge clk);
      sw_if.tick_1hz    = t1;
      sw_if.tick_2hz    = t2;
      sw_if.tick_blink  = tb;
      sw_if.pause_pulse = pp;
      sw_if.adj         = a;
      sw_if.sel         = s;
      model_step(t1, t2, tb, pp, a, s);
      exp_q.push_back(model_obs());
   endtask

   task automatic set_time(input int mm, input int ss);
      if (m_mode == MPaused) cyc(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 70 && (m_sec / 60) != mm; i++) cyc(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 70 && (m_sec % 60) != ss; i++) cyc(0, 1, 0, 0, 1, 1);
   endtask

   // Monitor: outputs are valid every cycle out of reset.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst && exp_q.size() > 0) check("scoreboard", dut_obs(), exp_q.pop_front());
      end
   end

   initial begin
      bit ra, rs;
      sw_if.tick_1hz    = 1'b0;
      sw_if.tick_2hz    = 1'b0;
      sw_if.tick_blink  = 1'b0;
      sw_if.pause_pulse = 1'b0;
      sw_if.adj         = 1'b0;
      sw_if.sel         = 1'b0;
      rst = 1'b0;
      #12;
      check("reset_state", dut_obs(), model_obs());
      @(negedge clk);
      rst = 1'b1;

      // 61 seconds in RUN -> 01:01
      for (int i = 0; i < 61; i++) cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // 59:58 then two seconds -> 00:00
      set_time(59, 58);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // 00:59, switch to ADJ_MIN, coincident ticks, then ignored 1 Hz
      for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);

      // Pause coincident with tick at 00:10
      set_time(0, 10);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 1, 1);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);

      // Blink in ADJ_SEC, then move to ADJ_MIN with a coincident blink tick
      cyc(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 1);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // Asynchronous reset mid-run at 12:34
      set_time(12, 34);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      m_sec = 0; m_mode = MRun; m_phase = 1'b0;
      #1;
      check("async_clear", dut_obs(), model_obs());
      sw_if.tick_1hz = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hold_in_reset", dut_obs(), model_obs());
      rst = 1'b1;
      sw_if.tick_1hz = 1'b0;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);

      // Random traffic
      ra = 1'b0;
      rs = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) ra = ~ra;
         if ($urandom_range(0, 31) == 0) rs = ~rs;
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0), ra, rs);
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
